// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Multiply uses radix-2 shift-add. Divide uses restoring division.
// Both work on operand magnitudes, and the result signs are fixed up in FINISH.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | waiting for start; mthi/mtlo writes accepted
//   RUN    | one multiply/divide iteration per clock, cnt counts down
//   FINISH | sign fix-up and hi/lo write (or zero-divide flag), done next

module mult_div_unit #(
   parameter int n     = 32,
   parameter int CNT_W = 6
) (
   input  logic         CLK,
   input  logic         rst,
   input  logic         start,
   input  logic [1:0]   op,
   input  logic [n-1:0] srcA,
   input  logic [n-1:0] srcB,
   input  logic         hi_we,
   input  logic         lo_we,
   output logic         busy,
   output logic         done,
   output logic         div_by_zero,
   output logic [n-1:0] hi,
   output logic [n-1:0] lo
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] RUN    = 2'd1;
   localparam logic [1:0] FINISH = 2'd2;

   logic [1:0]     state;
   logic [CNT_W-1:0] cnt;
   logic           op_div;
   logic           zdiv;
   logic           neg_q;
   logic           neg_r;
   logic [2*n-1:0] prod;
   logic [n-1:0]   mag_a;
   logic [n-1:0]   mag_b;
   logic [n-1:0]   rem;

   logic           op_sgn;
   logic [n-1:0]   abs_a;
   logic [n-1:0]   abs_b;
   logic [n:0]     mul_sum;
   logic [2*n-1:0] prod_next;
   logic [n:0]     shifted;
   logic           ge;
   logic [n-1:0]   rem_next;
   logic [n-1:0]   quo_next;
   logic [2*n-1:0] prod_res;
   logic [n-1:0]   quo_res;
   logic [n-1:0]   rem_res;

   // Operand magnitudes, one iteration step of each algorithm, and final sign fix-up.
   always_comb begin
      op_sgn    = ~op[0];
      abs_a     = (op_sgn && srcA[n-1]) ? -srcA : srcA;
      abs_b     = (op_sgn && srcB[n-1]) ? -srcB : srcB;

      // The multiplier is held in the low half of prod and shifts out bit 0 each step.
      mul_sum   = {1'b0, prod[2*n-1:n]} + (prod[0] ? {1'b0, mag_a} : '0);
      prod_next = {mul_sum, prod[n-1:1]};

      // The dividend shifts out MSB-first from mag_a, while quotient bits shift into its LSB.
      // The partial remainder is always below the divisor, so an n-bit difference is exact.
      shifted   = {rem, mag_a[n-1]};
      ge        = (shifted >= {1'b0, mag_b});
      rem_next  = ge ? (shifted[n-1:0] - mag_b) : shifted[n-1:0];
      quo_next  = {mag_a[n-2:0], ge};

      prod_res  = neg_q ? -prod : prod;
      quo_res   = neg_q ? -mag_a : mag_a;
      rem_res   = neg_r ? -rem : rem;
   end

   // Sequencing FSM, iteration datapath, and status outputs.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         op_div      <= 1'b0;
         zdiv        <= 1'b0;
         neg_q       <= 1'b0;
         neg_r       <= 1'b0;
         prod        <= '0;
         mag_a       <= '0;
         mag_b       <= '0;
         rem         <= '0;
         busy        <= 1'b0;
         done        <= 1'b0;
         div_by_zero <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE: begin
               if (start) begin
                  op_div      <= op[1];
                  neg_q       <= op_sgn & (srcA[n-1] ^ srcB[n-1]);
                  neg_r       <= op_sgn & srcA[n-1];
                  mag_a       <= abs_a;
                  mag_b       <= abs_b;
                  prod        <= {{n{1'b0}}, abs_b};
                  rem         <= '0;
                  cnt         <= CNT_W'(n);
                  div_by_zero <= 1'b0;
                  busy        <= 1'b1;
                  if (op[1] && (srcB == '0)) begin
                     zdiv  <= 1'b1;
                     state <= FINISH;
                  end else begin
                     zdiv  <= 1'b0;
                     state <= RUN;
                  end
               end
            end
            RUN: begin
               if (op_div) begin
                  rem   <= rem_next;
                  mag_a <= quo_next;
               end else begin
                  prod  <= prod_next;
               end
               cnt <= cnt - 1'b1;
               if (cnt == CNT_W'(1))
                  state <= FINISH;
            end
            FINISH: begin
               busy  <= 1'b0;
               done  <= 1'b1;
               state <= IDLE;
               if (zdiv)
                  div_by_zero <= 1'b1;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

   // HI/LO: operation results in FINISH; mthi/mtlo only when idle with no start.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         hi <= '0;
         lo <= '0;
      end else if (state == FINISH) begin
         if (!zdiv) begin
            if (op_div) begin
               lo <= quo_res;
               hi <= rem_res;
            end else begin
               {hi, lo} <= prod_res;
            end
         end
      end else if (state == IDLE && !start) begin
         if (hi_we)
            hi <= srcA;
         if (lo_we)
            lo <= srcA;
      end
   end

endmodule
